// File: rtl/spart_word_if.sv
// 32-bit word adapter over a byte-wide SPART: little-endian byte serializer on TX,
// byte assembler with overrun and inter-byte timeout detection on RX.
module spart_word_if #(
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        word_snd,
    input  logic [31:0] word_tx,
    output logic        tx_busy,
    output logic        byte_send,
    output logic [7:0]  byte_tx,
    input  logic        tbr,
    input  logic        rda,
    input  logic [7:0]  byte_rx,
    output logic        byte_ack,
    output logic [31:0] word_rx,
    output logic        word_valid,
    input  logic        word_ack,
    output logic        rx_err
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_WAIT_TBR,
        TX_SEND,
        TX_GUARD
    } tx_state_t;

    tx_state_t        tx_state;
    logic [1:0]       tx_idx;
    logic [3:0][7:0]  tx_word;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tx_state  <= TX_IDLE;
            tx_idx    <= 2'd0;
            tx_word   <= '0;
            tx_busy   <= 1'b0;
            byte_send <= 1'b0;
            byte_tx   <= 8'h00;
        end else begin
            byte_send <= 1'b0;
            case (tx_state)
                TX_IDLE: begin
                    if (word_snd) begin
                        tx_word  <= word_tx;
                        tx_idx   <= 2'd0;
                        tx_busy  <= 1'b1;
                        tx_state <= TX_WAIT_TBR;
                    end
                end
                TX_WAIT_TBR: begin
                    // Strobe is registered here so it is high exactly during SEND
                    if (tbr) begin
                        byte_send <= 1'b1;
                        byte_tx   <= tx_word[tx_idx];
                        tx_state  <= TX_SEND;
                    end
                end
                TX_SEND: tx_state <= TX_GUARD;
                TX_GUARD: begin
                    if (tx_idx == 2'd3) begin
                        tx_busy  <= 1'b0;
                        tx_state <= TX_IDLE;
                    end else begin
                        tx_idx   <= tx_idx + 2'd1;
                        tx_state <= TX_WAIT_TBR;
                    end
                end
                default: tx_state <= TX_IDLE;
            endcase
        end
    end

    logic             rda_q;
    logic             rx_rise;
    logic [1:0]       rx_idx;
    logic [2:0][7:0]  rx_slot;
    logic [TW-1:0]    rx_timer;

    assign rx_rise = rda & ~rda_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rda_q      <= 1'b0;
            rx_idx     <= 2'd0;
            rx_slot    <= '0;
            rx_timer   <= '0;
            byte_ack   <= 1'b0;
            word_rx    <= 32'h0;
            word_valid <= 1'b0;
            rx_err     <= 1'b0;
        end else begin
            rda_q    <= rda;
            byte_ack <= rx_rise;
            if (word_ack) begin
                word_valid <= 1'b0;
                rx_err     <= 1'b0;
            end
            if (rx_rise) begin
                rx_timer <= '0;
                if (rx_idx == 2'd3) begin
                    rx_idx <= 2'd0;
                    // A same-cycle ack frees the holding register for the new word
                    if (!word_valid || word_ack) begin
                        word_rx    <= {byte_rx, rx_slot[2], rx_slot[1], rx_slot[0]};
                        word_valid <= 1'b1;
                    end else begin
                        rx_err <= 1'b1;
                    end
                end else begin
                    rx_slot[rx_idx] <= byte_rx;
                    rx_idx          <= rx_idx + 2'd1;
                end
            end else if (rx_idx != 2'd0) begin
                if (rx_timer == TW'(TIMEOUT_CYCLES)) begin
                    rx_idx   <= 2'd0;
                    rx_timer <= '0;
                    rx_err   <= 1'b1;
                end else begin
                    rx_timer <= rx_timer + TW'(1);
                end
            end else begin
                rx_timer <= '0;
            end
        end
    end

endmodule

// File: tb/tb_spart_word_if.sv
// Randomized self-checking bench for spart_word_if: TX byte stream checked against the
// word's little-endian bytes, RX checked against an event-level word assembly model.
module tb_spart_word_if;

    localparam int T = 20;

    logic        clk = 1'b0;
    logic        rst_n, word_snd, tbr, rda, word_ack;
    logic [31:0] word_tx;
    logic [7:0]  byte_rx;
    logic        tx_busy, byte_send, byte_ack, word_valid, rx_err;
    logic [7:0]  byte_tx;
    logic [31:0] word_rx;

    spart_word_if #(.TIMEOUT_CYCLES(T)) dut (
        .clk(clk), .rst_n(rst_n), .word_snd(word_snd), .word_tx(word_tx),
        .tx_busy(tx_busy), .byte_send(byte_send), .byte_tx(byte_tx), .tbr(tbr),
        .rda(rda), .byte_rx(byte_rx), .byte_ack(byte_ack), .word_rx(word_rx),
        .word_valid(word_valid), .word_ack(word_ack), .rx_err(rx_err)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int ack_cnt = 0;
    logic [7:0] tx_q[$];
    int         tx_cyc[$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (byte_send === 1'b1) begin
            tx_q.push_back(byte_tx);
            tx_cyc.push_back(cyc);
        end
        if (byte_ack === 1'b1) ack_cnt++;
    end

    // RX reference: bytes received so far in the current word, and the holding register
    logic [7:0]  m_part[$];
    logic [31:0] m_word;
    bit          m_valid, m_err;
    int          m_last;

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic model_rx_reset();
        m_part.delete();
        m_word  = 32'h0;
        m_valid = 1'b0;
        m_err   = 1'b0;
        m_last  = cyc;
    endtask

    task automatic snd(input logic [31:0] w);
        word_tx  = w;
        word_snd = 1'b1;
        tick(1);
        word_snd = 1'b0;
        word_tx  = $urandom;
    endtask

    task automatic rx_byte(input logic [7:0] b, input int gap, input bit ack_with);
        int a0;
        logic [31:0] w;
        a0 = ack_cnt;
        byte_rx  = b;
        rda      = 1'b1;
        word_ack = ack_with;
        tick(1);
        word_ack = 1'b0;
        if (m_part.size() > 0 && cyc - m_last > T + 1) begin
            m_part.delete();
            m_err = 1'b1;
        end
        if (ack_with) begin
            m_valid = 1'b0;
            m_err   = 1'b0;
        end
        m_part.push_back(b);
        m_last = cyc;
        if (m_part.size() == 4) begin
            w = 32'h0;
            foreach (m_part[i]) w = w + (32'(m_part[i]) << (8 * i));
            if (m_valid) m_err = 1'b1;
            else begin
                m_word  = w;
                m_valid = 1'b1;
            end
            m_part.delete();
        end
        total++;
        if (byte_ack !== 1'b1) begin
            bad++;
            $display("FAIL byte_ack_latency: got %b want 1", byte_ack);
        end
        total++;
        if (word_valid !== m_valid || word_rx !== m_word) begin
            bad++;
            $display("FAIL rx_word: got v=%b %h want v=%b %h", word_valid, word_rx, m_valid, m_word);
        end
        total++;
        if (rx_err !== m_err) begin
            bad++;
            $display("FAIL rx_err: got %b want %b", rx_err, m_err);
        end
        rda     = 1'b0;
        byte_rx = $urandom;
        tick(gap);
        total++;
        if (ack_cnt != a0 + 1) begin
            bad++;
            $display("FAIL byte_ack_count: got %0d want %0d", ack_cnt - a0, 1);
        end
    endtask

    task automatic pulse_ack();
        word_ack = 1'b1;
        tick(1);
        word_ack = 1'b0;
        m_valid = 1'b0;
        m_err   = 1'b0;
        total++;
        if (word_valid !== 1'b0 || rx_err !== 1'b0) begin
            bad++;
            $display("FAIL word_ack_clear: got v=%b e=%b want 0 0", word_valid, rx_err);
        end
    endtask

    task automatic wait_tx_idle(input string name);
        int n;
        n = 0;
        while (tx_busy === 1'b1 && n < 400) begin
            tick(1);
            n++;
        end
        if (tx_busy !== 1'b0) begin
            total++;
            bad++;
            $display("FAIL %s_timeout: got busy=%b want 0", name, tx_busy);
        end
        tick(1);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; word_snd = 1'b0; word_tx = 32'h0; tbr = 1'b1;
        rda = 1'b0; byte_rx = 8'h0; word_ack = 1'b0;
        tick(2);
        total++;
        if ({tx_busy, byte_send, byte_tx} !== 10'h0) begin
            bad++;
            $display("FAIL reset_tx: got %b %b %h want 0 0 00", tx_busy, byte_send, byte_tx);
        end
        total++;
        if ({byte_ack, word_valid, rx_err} !== 3'b0 || word_rx !== 32'h0) begin
            bad++;
            $display("FAIL reset_rx: got %b %b %b %h want 0 0 0 0", byte_ack, word_valid, rx_err, word_rx);
        end
        rst_n = 1'b1;
        tick(1);
        model_rx_reset();
    endtask

    task automatic test_tx_basic();
        logic [31:0] w;
        w = 32'hDEADBEEF;
        tx_q.delete(); tx_cyc.delete();
        tbr = 1'b1;
        snd(w);
        total++;
        if (tx_busy !== 1'b1) begin
            bad++;
            $display("FAIL tx_busy_rise: got %b want 1", tx_busy);
        end
        tick(2);
        snd($urandom);          // must be ignored while busy
        tick(8);
        total++;
        if (tx_busy !== 1'b1) begin
            bad++;
            $display("FAIL tx_busy_last_guard: got %b want 1", tx_busy);
        end
        snd($urandom);          // lands on the cycle busy falls: must be ignored
        total++;
        if (tx_busy !== 1'b0) begin
            bad++;
            $display("FAIL tx_busy_fall: got %b want 0", tx_busy);
        end
        tick(10);
        total++;
        if (tx_busy !== 1'b0 || tx_q.size() != 4) begin
            bad++;
            $display("FAIL tx_basic_count: got busy=%b n=%0d want 0 4", tx_busy, tx_q.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                total++;
                if (tx_q[i] !== 8'((w >> (8 * i)) & 32'hFF)) begin
                    bad++;
                    $display("FAIL tx_basic_byte%0d: got %h want %h", i, tx_q[i], 8'((w >> (8 * i)) & 32'hFF));
                end
                if (i > 0) begin
                    total++;
                    if (tx_cyc[i] - tx_cyc[i-1] != 3) begin
                        bad++;
                        $display("FAIL tx_spacing%0d: got %0d want 3", i, tx_cyc[i] - tx_cyc[i-1]);
                    end
                end
            end
        end
    endtask

    task automatic test_tx_stall();
        int n;
        tx_q.delete(); tx_cyc.delete();
        tbr = 1'b1;
        snd(32'hDEADBEEF);
        n = 0;
        while (tx_q.size() < 2 && n < 20) begin
            tick(1);
            n++;
        end
        tbr = 1'b0;
        tick(100);
        total++;
        if (tx_q.size() != 2 || tx_busy !== 1'b1) begin
            bad++;
            $display("FAIL tx_stall: got n=%0d busy=%b want 2 1", tx_q.size(), tx_busy);
        end
        tbr = 1'b1;
        tick(1);
        total++;
        if (byte_send !== 1'b1 || byte_tx !== 8'hAD) begin
            bad++;
            $display("FAIL tx_resume: got %b %h want 1 ad", byte_send, byte_tx);
        end
        wait_tx_idle("tx_stall");
        total++;
        if (tx_q.size() != 4 || tx_q[0] !== 8'hEF || tx_q[1] !== 8'hBE || tx_q[3] !== 8'hDE) begin
            bad++;
            $display("FAIL tx_stall_bytes: got n=%0d want EF BE AD DE", tx_q.size());
        end
    endtask

    task automatic test_tx_random();
        logic [31:0] w;
        int n;
        for (int k = 0; k < 6; k++) begin
            w = $urandom;
            tx_q.delete(); tx_cyc.delete();
            snd(w);
            n = 0;
            while (tx_busy === 1'b1 && n < 300) begin
                tbr = 1'($urandom_range(0, 1));
                tick(1);
                n++;
            end
            tbr = 1'b1;
            tick(1);
            total++;
            if (tx_busy !== 1'b0 || tx_q.size() != 4) begin
                bad++;
                $display("FAIL tx_rand_count: got busy=%b n=%0d want 0 4", tx_busy, tx_q.size());
            end else begin
                for (int i = 0; i < 4; i++) begin
                    total++;
                    if (tx_q[i] !== 8'((w >> (8 * i)) & 32'hFF)) begin
                        bad++;
                        $display("FAIL tx_rand_byte%0d: got %h want %h", i, tx_q[i], 8'((w >> (8 * i)) & 32'hFF));
                    end
                end
            end
        end
    endtask

    task automatic test_rx_basic();
        rx_byte(8'h11, 2, 0); rx_byte(8'h22, 2, 0);
        rx_byte(8'h33, 2, 0); rx_byte(8'h44, 2, 0);
        total++;
        if (word_rx !== 32'h44332211 || word_valid !== 1'b1) begin
            bad++;
            $display("FAIL rx_basic: got %h v=%b want 44332211 1", word_rx, word_valid);
        end
    endtask

    task automatic test_rx_overrun();
        rx_byte(8'h55, 2, 0); rx_byte(8'h66, 2, 0);
        rx_byte(8'h77, 2, 0); rx_byte(8'h88, 2, 0);
        total++;
        if (word_rx !== 32'h44332211 || rx_err !== 1'b1) begin
            bad++;
            $display("FAIL rx_overrun: got %h e=%b want 44332211 1", word_rx, rx_err);
        end
        pulse_ack();
    endtask

    task automatic test_rx_ack_same_cycle();
        rx_byte(8'h01, 1, 0); rx_byte(8'h02, 1, 0); rx_byte(8'h03, 1, 0); rx_byte(8'h04, 1, 0);
        rx_byte(8'hA1, 1, 0); rx_byte(8'hA2, 1, 0); rx_byte(8'hA3, 1, 0); rx_byte(8'hA4, 1, 1);
        total++;
        if (word_rx !== 32'hA4A3A2A1 || word_valid !== 1'b1 || rx_err !== 1'b0) begin
            bad++;
            $display("FAIL rx_ack_same: got %h v=%b e=%b want a4a3a2a1 1 0", word_rx, word_valid, rx_err);
        end
        pulse_ack();
    endtask

    task automatic test_rx_timeout();
        rx_byte(8'hAA, 2, 0);
        rx_byte(8'hBB, 25, 0);
        rx_byte(8'h01, 2, 0); rx_byte(8'h02, 2, 0);
        rx_byte(8'h03, 2, 0); rx_byte(8'h04, 2, 0);
        total++;
        if (word_rx !== 32'h04030201 || rx_err !== 1'b1) begin
            bad++;
            $display("FAIL rx_timeout: got %h e=%b want 04030201 1", word_rx, rx_err);
        end
        pulse_ack();
    endtask

    task automatic test_rx_random();
        int gap;
        for (int k = 0; k < 48; k++) begin
            gap = ($urandom_range(0, 7) == 0) ? int'($urandom_range(25, 30)) : int'($urandom_range(1, 12));
            rx_byte(8'($urandom), gap, 0);
            if (m_part.size() == 0 && m_valid && $urandom_range(0, 1) == 1) pulse_ack();
        end
        tick(T + 5);
        if (m_part.size() > 0) begin
            m_part.delete();
            m_err = 1'b1;
        end
        total++;
        if (rx_err !== m_err || word_valid !== m_valid || word_rx !== m_word) begin
            bad++;
            $display("FAIL rx_rand_final: got e=%b v=%b %h want %b %b %h", rx_err, word_valid, word_rx, m_err, m_valid, m_word);
        end
        pulse_ack();
    endtask

    task automatic test_concurrent();
        logic [31:0] w;
        w = $urandom;
        tx_q.delete(); tx_cyc.delete();
        tbr = 1'b1;
        fork
            begin
                snd(w);
                wait_tx_idle("conc");
            end
            begin
                for (int i = 0; i < 4; i++) rx_byte(8'($urandom), 1, 0);
            end
        join
        total++;
        if (tx_q.size() != 4 || {tx_q[3], tx_q[2], tx_q[1], tx_q[0]} !== w) begin
            bad++;
            $display("FAIL conc_tx: got n=%0d want %h", tx_q.size(), w);
        end
        pulse_ack();
    endtask

    task automatic test_reset_mid();
        logic [31:0] w;
        int n;
        rx_byte(8'h5A, 1, 0);
        rx_byte(8'hA5, 1, 0);
        tx_q.delete(); tx_cyc.delete();
        tbr = 1'b1;
        snd(32'hCAFEF00D);
        n = 0;
        while (tx_q.size() < 1 && n < 20) begin
            tick(1);
            n++;
        end
        rst_n = 1'b0;
        tick(1);
        rst_n = 1'b1;
        model_rx_reset();
        total++;
        if ({tx_busy, byte_send, byte_tx, byte_ack, word_valid, rx_err} !== 13'h0 || word_rx !== 32'h0) begin
            bad++;
            $display("FAIL reset_mid: got %b %b %h %b %b %b %h want all 0",
                     tx_busy, byte_send, byte_tx, byte_ack, word_valid, rx_err, word_rx);
        end
        tx_q.delete(); tx_cyc.delete();
        tick(10);
        total++;
        if (tx_q.size() != 0) begin
            bad++;
            $display("FAIL reset_abort: got %0d sends want 0", tx_q.size());
        end
        w = $urandom;
        snd(w);
        wait_tx_idle("post_reset");
        total++;
        if (tx_q.size() != 4 || {tx_q[3], tx_q[2], tx_q[1], tx_q[0]} !== w) begin
            bad++;
            $display("FAIL post_reset_tx: got n=%0d want %h", tx_q.size(), w);
        end
        rx_byte(8'hC1, 2, 0); rx_byte(8'hC2, 2, 0); rx_byte(8'hC3, 2, 0); rx_byte(8'hC4, 2, 0);
        total++;
        if (word_rx !== 32'hC4C3C2C1 || word_valid !== 1'b1) begin
            bad++;
            $display("FAIL post_reset_rx: got %h v=%b want c4c3c2c1 1", word_rx, word_valid);
        end
    endtask

    initial begin
        test_reset();
        test_tx_basic();
        test_tx_stall();
        test_tx_random();
        test_rx_basic();
        test_rx_overrun();
        test_rx_ack_same_cycle();
        test_rx_timeout();
        test_rx_random();
        test_concurrent();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/spart_word_if.md
SPART_WORD_IF -- requirements
Module: spart_word_if

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 50000, SHALL set the inter-byte receive timeout in clk cycles.
REQ-002 clk  input  1  SHALL be the single clock; all logic is on its rising edge.
REQ-003 rst_n  input  1  SHALL be the reset: synchronous, active-low.
REQ-004 word_snd  input  1  SHALL request transmission of word_tx (1-cycle pulse).
REQ-005 word_tx  input  32  SHALL be the word to transmit, sampled when word_snd is accepted.
REQ-006 tx_busy  output  1  SHALL be high while a word is being sent.
REQ-007 byte_send  output  1  SHALL be the 1-cycle send strobe to the SPART transmitter.
REQ-008 byte_tx  output  8  SHALL be the byte to the SPART transmitter, valid while byte_send is high.
REQ-009 tbr  input  1  SHALL be the SPART transmit-buffer-ready flag.
REQ-010 rda  input  1  SHALL be the SPART receive-data-available flag.
REQ-011 byte_rx  input  8  SHALL be the SPART received byte.
REQ-012 byte_ack  output  1  SHALL pulse for 1 cycle when a received byte has been taken.
REQ-013 word_rx  output  32  SHALL be the last assembled received word.
REQ-014 word_valid  output  1  SHALL be high while word_rx holds an unacknowledged word (board interrupt).
REQ-015 word_ack  input  1  SHALL acknowledge word_rx; 1-cycle pulse.
REQ-016 rx_err  output  1  SHALL be the sticky receive error flag (overrun or timeout).

Function
REQ-017 Byte order SHALL be little-endian on both paths: byte 0 = bits [7:0], byte 3 = bits [31:24].
REQ-018 TX FSM SHALL have states IDLE, WAIT_TBR, SEND, GUARD, with a 2-bit byte index.
REQ-019 IDLE: on word_snd=1, SHALL capture word_tx, clear the index to 0, and go to WAIT_TBR; tx_busy goes high the next cycle.
REQ-020 WAIT_TBR: SHALL stay until tbr=1, then go to SEND.
REQ-021 SEND: SHALL drive byte_send=1 for exactly 1 cycle with byte_tx = the captured word at the current index, then go to GUARD.
REQ-022 GUARD: SHALL last 1 cycle with tbr ignored. If index=3, go to IDLE with tx_busy=0 the next cycle; otherwise increment the index and go to WAIT_TBR.
REQ-023 word_snd while tx_busy=1 SHALL be ignored; the captured word SHALL NOT change mid-transmission.
REQ-024 word_snd in the same cycle tx_busy falls SHALL NOT be accepted; acceptance happens only in IDLE.
REQ-025 RX SHALL accept a byte on a rising edge of rda (rda=1 and the registered previous rda=0), storing byte_rx into the byte slot at the RX index.
REQ-026 byte_ack SHALL be asserted the cycle after each accepted byte.
REQ-027 On accepting byte index 3, the RX path SHALL behave as follows:
  - if word_valid=0: load all 32 assembled bits into word_rx and set word_valid=1 the next cycle;
  - if word_valid=1: discard the new word, keep word_rx unchanged, and set rx_err=1 (overrun).
  - In both cases the RX index wraps to 0.
REQ-028 word_ack SHALL clear word_valid and rx_err the next cycle. word_ack in the same cycle as a word completion SHALL clear the old word and load the new one, with word_valid staying 1 and no overrun.
REQ-029 Inter-byte timer: while the RX index is 1..3, the timer SHALL count cycles since the last accepted byte. Reaching TIMEOUT_CYCLES SHALL clear the RX index to 0, discard the partial bytes, and set rx_err=1.
REQ-030 The timer SHALL be held at 0 while the RX index is 0, and cleared on every accepted byte.
REQ-031 The timer width SHALL be $clog2(TIMEOUT_CYCLES+1) bits and SHALL NOT wrap.
REQ-032 The TX and RX paths SHALL be fully independent; simultaneous activity SHALL have no interaction.

Reset
REQ-033 With rst_n=0 at a clock edge, both FSMs SHALL go to IDLE / index 0 and the timer SHALL clear.
REQ-034 Outputs SHALL reset to tx_busy=0, byte_send=0, byte_tx=8'h00, byte_ack=0, word_rx=32'h0, word_valid=0, rx_err=0.
REQ-035 Reset mid-word SHALL abort the transfer with no further byte_send, and SHALL discard partial RX bytes.

Verification
REQ-036 word_tx=32'hDEADBEEF with word_snd pulsed, tbr held 1 -> byte_send pulses carry EF, BE, AD, DE, one every 3 cycles; tx_busy=0 after the last GUARD.
REQ-037 tbr held 0 for 100 cycles before byte 2 -> no byte_send during the stall; bytes EF, BE, then AD within 1 cycle of tbr=1.
REQ-038 rda rising edges with bytes 11, 22, 33, 44 -> word_rx=32'h44332211, word_valid=1, four byte_ack pulses.
REQ-039 Second word 55, 66, 77, 88 arrives without word_ack -> word_rx stays 32'h44332211 and rx_err=1; word_ack clears both flags.
REQ-040 TIMEOUT_CYCLES=20, bytes AA, BB, then 25 idle cycles, then 01, 02, 03, 04 -> rx_err=1 and word_rx=32'h04030201.
REQ-041 rst_n=0 for 1 cycle during TX byte 1 and RX byte 2 -> all outputs at reset values; a subsequent full word on each path completes correctly.
